ln_2to1_arb: RTL and testbench

- Merges two 4-phase req/ack source channels (addr+dat) onto one downstream 4-phase channel.
- Round-robin arbiter; the inverse of the 1-to-2 line splitter.
- Sits between two producers and a single sink in the hlang link-test fabric.
- Captures the winning source's addr/dat, runs one full downstream handshake, then completes the upstream handshake.

---
 rtl/ln_2to1_arb_pkg.sv | 18 +
 rtl/arb_rr2_pick.sv | 21 ++
 rtl/ln_2to1_arb.sv | 141 ++++++++++++++
 tb/tb_ln_2to1_arb.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ln_2to1_arb_pkg.sv
// Shared definitions for the 2-to-1 line arbiter: default widths, on/off levels
// and the arbiter state encoding.
package ln_2to1_arb_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int ADDRESS_SIZE = 8;
  localparam int DATA_SIZE    = 16;

  // 2'd3 is unused and recovers to ARB_IDLE
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_SEND  = 2'd1,
    ARB_ACKUP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_rr2_pick.sv
// Combinational 2-way picker: a lone requester wins; on a tie the source not
// served last wins when fair, otherwise source 0 wins.
module arb_rr2_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fair,
  output logic       valid,
  output logic       idx
);

  // Pick the winner from the request pair and the last-served index
  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      idx = fair ? ~last : 1'b0;
    end else begin
      idx = req[1];
    end
  end

endmodule

// File: rtl/ln_2to1_arb.sv
// Merges two 4-phase req/ack sources onto one downstream 4-phase channel,
// latching the winner's addr/dat at grant and finishing downstream before upstream.
module ln_2to1_arb
  import ln_2to1_arb_pkg::*;
#(
  parameter int ASZ  = ADDRESS_SIZE,
  parameter int DSZ  = DATA_SIZE,
  parameter bit FAIR = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [ASZ-1:0] i_0_addr,
  input  logic [DSZ-1:0] i_0_dat,
  input  logic           i_0_req,
  output logic           o_0_ack,
  input  logic [ASZ-1:0] i_1_addr,
  input  logic [DSZ-1:0] i_1_dat,
  input  logic           i_1_req,
  output logic           o_1_ack,
  output logic [ASZ-1:0] o_addr,
  output logic [DSZ-1:0] o_dat,
  output logic           o_req,
  input  logic           i_ack,
  output logic           o_busy,
  output logic           o_gnt
);

  arb_state_e     state_q, state_d;
  logic [ASZ-1:0] addr_q, addr_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic           req_q, req_d;
  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;
  logic           busy_q, busy_d;
  logic           gnt_q, gnt_d;
  logic           last_q, last_d;
  logic           pick_valid_s;
  logic           pick_idx_s;
  logic           gnt_req_s;

  arb_rr2_pick u_pick (
    .req   ({i_1_req, i_0_req}),
    .last  (last_q),
    .fair  (FAIR),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Next-state and next-output logic for the grant / send / ack-up sequence
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dat_d     = dat_q;
    req_d     = req_q;
    ack0_d    = ack0_q;
    ack1_d    = ack1_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    gnt_req_s = gnt_q ? i_1_req : i_0_req;
    case (state_q)
      ARB_IDLE: begin
        // a still-high i_ack belongs to the previous transfer, so hold off
        if (!i_ack && pick_valid_s) begin
          state_d = ARB_SEND;
          gnt_d   = pick_idx_s;
          req_d   = ON;
          if (pick_idx_s) begin
            addr_d = i_1_addr;
            dat_d  = i_1_dat;
          end else begin
            addr_d = i_0_addr;
            dat_d  = i_0_dat;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_SEND: begin
        if (i_ack) begin
          state_d = ARB_ACKUP;
          req_d   = OFF;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
        end else begin
          state_d = ARB_SEND;
        end
      end
      ARB_ACKUP: begin
        if (!gnt_req_s) begin
          state_d = ARB_IDLE;
          ack0_d  = OFF;
          ack1_d  = OFF;
          last_d  = gnt_q;
        end else begin
          state_d = ARB_ACKUP;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        req_d   = OFF;
        ack0_d  = OFF;
        ack1_d  = OFF;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      addr_q  <= {ASZ{1'b0}};
      dat_q   <= {DSZ{1'b0}};
      req_q   <= OFF;
      ack0_q  <= OFF;
      ack1_q  <= OFF;
      busy_q  <= OFF;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      req_q   <= req_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign o_addr  = addr_q;
  assign o_dat   = dat_q;
  assign o_req   = req_q;
  assign o_0_ack = ack0_q;
  assign o_1_ack = ack1_q;
  assign o_busy  = busy_q;
  assign o_gnt   = gnt_q;

endmodule

// File: tb/tb_ln_2to1_arb.sv
// Scoreboard bench for ln_2to1_arb: producer tasks queue expected transfers,
// a monitor derives the winner from sampled requests and checks each grant/ack.
module tb_ln_2to1_arb;
  import ln_2to1_arb_pkg::*;

  localparam int ASZ = ADDRESS_SIZE;
  localparam int DSZ = DATA_SIZE;

  typedef struct packed {
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] dat;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ASZ-1:0] s_addr [2];
  logic [DSZ-1:0] s_dat  [2];
  logic           s_req  [2];
  logic           i_ack;
  logic           o_0_ack, o_1_ack, o_req, o_busy, o_gnt;
  logic [ASZ-1:0] o_addr;
  logic [DSZ-1:0] o_dat;

  ln_2to1_arb #(.ASZ(ASZ), .DSZ(DSZ), .FAIR(1'b1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_0_addr(s_addr[0]), .i_0_dat(s_dat[0]), .i_0_req(s_req[0]), .o_0_ack(o_0_ack),
    .i_1_addr(s_addr[1]), .i_1_dat(s_dat[1]), .i_1_req(s_req[1]), .o_1_ack(o_1_ack),
    .o_addr(o_addr), .o_dat(o_dat), .o_req(o_req), .i_ack(i_ack),
    .o_busy(o_busy), .o_gnt(o_gnt)
  );

  // Second instance with fixed priority
  logic           b_en = 1'b0, b_req0, b_req1 = 1'b0, b_iack, b_prev;
  logic [ASZ-1:0] b_addr = 8'hB0;
  logic [DSZ-1:0] b_d0 = 16'h0000, b_d1 = 16'h0900;
  logic           b_o0ack, b_o1ack, b_oreq, b_busy, b_gnt;
  logic [ASZ-1:0] b_oaddr;
  logic [DSZ-1:0] b_odat;
  int             b_issued = 0, b_cnt = 0;
  logic [DSZ-1:0] b_exp [$];

  ln_2to1_arb #(.ASZ(ASZ), .DSZ(DSZ), .FAIR(1'b0)) u_dut_fixed (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_0_addr(b_addr), .i_0_dat(b_d0), .i_0_req(b_req0), .o_0_ack(b_o0ack),
    .i_1_addr(b_addr), .i_1_dat(b_d1), .i_1_req(b_req1), .o_1_ack(b_o1ack),
    .o_addr(b_oaddr), .o_dat(b_odat), .o_req(b_oreq), .i_ack(b_iack),
    .o_busy(b_busy), .o_gnt(b_gnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  item_t exp_q0 [$];
  item_t exp_q1 [$];
  int    order_q [$];

  // Requests and ack as seen by the DUT at each rising edge
  logic [1:0] smp_req = 2'b00;
  logic       smp_ack = 1'b0;
  always @(posedge clk) begin
    smp_req <= {s_req[1], s_req[0]};
    smp_ack <= i_ack;
  end

  // Monitor: reference arbitration + scoreboard compare
  logic  model_last = 1'b1, in_txn = 1'b0, prev_oreq = 1'b0, prev_a0 = 1'b0, prev_a1 = 1'b0;
  logic  cur_k = 1'b0, mk;
  item_t cur;
  int    qn;
  always @(negedge clk) begin
    if (!rst_n) begin
      model_last = 1'b1;
      in_txn     = 1'b0;
      prev_oreq  = 1'b0;
      prev_a0    = 1'b0;
      prev_a1    = 1'b0;
    end else begin
      chk("ack_onehot", o_0_ack & o_1_ack, 0);
      if (o_req && !prev_oreq) begin
        in_txn = 1'b1;
        chk("grant_has_req", smp_req != 2'b00, 1);
        chk("grant_ack_low", smp_ack, 0);
        mk = (smp_req == 2'b11) ? ~model_last : smp_req[1];
        chk("grant_idx", o_gnt, mk);
        qn = mk ? exp_q1.size() : exp_q0.size();
        chk("grant_pending", qn != 0, 1);
        if (qn != 0) cur = mk ? exp_q1[0] : exp_q0[0];
        cur_k = mk;
        chk("grant_addr", o_addr, cur.addr);
        chk("grant_dat", o_dat, cur.dat);
      end else if (o_req) begin
        chk("send_addr_stable", o_addr, cur.addr);
        chk("send_dat_stable", o_dat, cur.dat);
      end
      if ((o_0_ack && !prev_a0) || (o_1_ack && !prev_a1)) begin
        chk("ack_src", o_1_ack, cur_k);
        chk("ack_latency", {prev_oreq, smp_ack, o_req}, 3'b110);
        if (cur_k && exp_q1.size() != 0) void'(exp_q1.pop_front());
        if (!cur_k && exp_q0.size() != 0) void'(exp_q0.pop_front());
        model_last = cur_k;
        order_q.push_back(int'(cur_k));
      end
      if ((prev_a0 && !o_0_ack) || (prev_a1 && !o_1_ack)) in_txn = 1'b0;
      chk("busy", o_busy, in_txn);
      prev_oreq = o_req;
      prev_a0   = o_0_ack;
      prev_a1   = o_1_ack;
    end
  end

  // Sink: acks after a delay, optionally holds ack after o_req falls
  int   sink_delay = 0, sink_hold = 0, target = 0, wcnt = 0, hcnt = 0;
  logic sink_rand = 1'b0, arm = 1'b0;
  initial i_ack = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      i_ack = 1'b0;
      wcnt  = 0;
      hcnt  = 0;
      arm   = 1'b0;
    end else if (i_ack) begin
      chk("req_low_while_ack", o_req, 0);
      if (hcnt >= sink_hold) begin
        i_ack = 1'b0;
        arm   = (sink_hold > 0) && (s_req[0] || s_req[1]);
      end else begin
        hcnt++;
      end
    end else begin
      if (arm) begin
        chk("regrant_after_ack_drop", o_req, 1);
        arm = 1'b0;
      end
      if (o_req) begin
        if (wcnt >= target) begin
          i_ack  = 1'b1;
          hcnt   = 0;
          wcnt   = 0;
          target = sink_rand ? int'($urandom_range(3, 0)) : sink_delay;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Fixed-priority instance: src1 holds req, src0 re-requests at once, sink auto-acks
  always @(negedge clk) begin
    if (!rst_n) begin
      b_req0 = 1'b0;
      b_iack = 1'b0;
      b_prev = 1'b0;
    end else begin
      b_iack = b_oreq;
      b_req1 = b_en;
      if (b_oreq && !b_prev && b_cnt < 4) begin
        chk("fixed_gnt", b_gnt, 0);
        chk("fixed_dat", b_odat, (b_exp.size() != 0) ? b_exp.pop_front() : 16'hFFFF);
        b_cnt++;
      end
      if (b_en && b_cnt < 4) chk("fixed_no_src1_ack", b_o1ack, 0);
      if (b_req0 && b_o0ack) begin
        b_req0 = 1'b0;
      end else if (b_en && !b_req0 && !b_o0ack && b_issued < 4) begin
        b_issued++;
        b_d0 = 16'h0100 + DSZ'(b_issued);
        b_exp.push_back(b_d0);
        b_req0 = 1'b1;
      end
      b_prev = b_oreq;
    end
  end

  task automatic produce(input int k, input int n, input int maxgap, input logic [ASZ-1:0] abase,
                         input logic [DSZ-1:0] dbase, input bit rnd, input bit mut);
    item_t it;
    int    t;
    for (int i = 0; i < n; i++) begin
      it.addr = rnd ? ASZ'($urandom) : abase + ASZ'(i);
      it.dat  = rnd ? DSZ'($urandom) : dbase + DSZ'(i);
      if (k == 0) exp_q0.push_back(it);
      else        exp_q1.push_back(it);
      s_addr[k] = it.addr;
      s_dat[k]  = it.dat;
      s_req[k]  = 1'b1;
      if (mut) begin
        t = 0;
        while (!o_req && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        s_dat[k] = it.dat ^ DSZ'(16'h0011);
      end
      t = 0;
      while (!(k == 1 ? o_1_ack : o_0_ack) && t < 300) begin @(negedge clk); t++; end
      chk("ack_arrives", t < 300, 1);
      s_req[k] = 1'b0;
      @(negedge clk);
      chk("ack_release", k == 1 ? o_1_ack : o_0_ack, 0);
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req"}, o_req, 0);
    chk({tag, "_ack0"}, o_0_ack, 0);
    chk({tag, "_ack1"}, o_1_ack, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_dat"}, o_dat, 0);
    chk({tag, "_gnt"}, o_gnt, 0);
  endtask

  initial begin
    item_t it;
    int    t;
    for (int k = 0; k < 2; k++) begin
      s_req[k]  = 1'b0;
      s_addr[k] = '0;
      s_dat[k]  = '0;
    end
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single source-0 transfer, sink acks after 2 cycles
    sink_delay = 2; target = 2;
    produce(0, 1, 0, 8'h03, 16'h0011, 1'b0, 1'b0);

    // both held: strict alternation starting with source 0
    reset_dut();
    sink_delay = 0; target = 0;
    order_q.delete();
    fork
      produce(0, 4, 0, 8'h10, 16'h0001, 1'b0, 1'b0);
      produce(1, 4, 0, 8'h20, 16'h0081, 1'b0, 1'b0);
    join
    chk("alt_count", order_q.size(), 8);
    for (int i = 0; i < order_q.size(); i++) chk("alt_order", order_q[i], i % 2);

    // sink holds ack 5 cycles after o_req falls
    sink_hold = 5;
    fork
      produce(0, 2, 1, 8'h30, 16'h0201, 1'b0, 1'b0);
      produce(1, 3, 0, 8'h40, 16'h0301, 1'b0, 1'b0);
    join
    sink_hold = 0;

    // fixed-priority instance: four grants to source 0
    b_en = 1'b1;
    t = 0;
    while (b_cnt < 4 && t < 400) begin @(negedge clk); t++; end
    chk("fixed_four_grants", b_cnt, 4);
    repeat (4) @(negedge clk);
    b_en = 1'b0;
    repeat (6) @(negedge clk);

    // data changed after grant is not seen downstream
    sink_delay = 2; target = 2;
    produce(0, 1, 0, 8'h07, 16'h0022, 1'b0, 1'b1);

    // reset during SEND aborts; the request is re-granted with fresh data
    sink_delay = 4; target = 4;
    it.addr = 8'h05; it.dat = 16'h0044;
    exp_q0.push_back(it);
    s_addr[0] = it.addr; s_dat[0] = it.dat; s_req[0] = 1'b1;
    t = 0;
    while (!o_req && t < 50) begin @(negedge clk); t++; end
    chk("rst_test_grant", o_req, 1);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("async_rst");
    s_dat[0] = 16'h0055;
    exp_q0[0].dat = 16'h0055;
    @(negedge clk);
    #2 rst_n = 1'b1;
    t = 0;
    while (!o_0_ack && t < 50) begin @(negedge clk); t++; end
    chk("rst_test_ack", o_0_ack, 1);
    s_req[0] = 1'b0;
    @(negedge clk);
    chk("rst_test_release", o_0_ack, 0);

    // randomized traffic from both sources
    sink_rand = 1'b1;
    fork
      produce(0, 20, 3, 8'h00, 16'h0000, 1'b1, 1'b0);
      produce(1, 20, 3, 8'h00, 16'h0000, 1'b1, 1'b0);
    join
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
